// File: rtl/param_multiport_ram_pkg.sv
// -----------------------------------------------------------------------------
// param_multiport_ram_pkg
// Shared definitions for the parametrised multi-port RAM and the register-file
// blocks built on it: FSM state encodings, default geometry and a clog2 helper
// usable in constant (parameter) expressions.
// -----------------------------------------------------------------------------
package param_multiport_ram_pkg;

  // Controller states. ST_INIT runs the post-reset clear sweep, ST_RUN is
  // normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mpram_state_t;

  // Default geometry shared with the register-file blocks.
  localparam int MPRAM_DEF_NPORTS = 4;
  localparam int MPRAM_DEF_DW     = 8;
  localparam int MPRAM_DEF_DEPTH  = 16;

  // Ceiling log2; mpram_clog2(1) = 0, mpram_clog2(16) = 4, mpram_clog2(17) = 5.
  function automatic int mpram_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage : param_multiport_ram_pkg

// File: rtl/param_multiport_ram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mpram_wr_arbiter
// Combinational write-conflict arbiter. Among all ports that request a write
// to the same address in the same cycle, the lowest-index port is granted and
// every other requester on that address is dropped. Ports writing distinct
// addresses are all granted.
//
// Ports:
//   i_we    [NPORTS]      per-port write request
//   i_addr  [NPORTS*AW]   per-port address, port p at [p*AW +: AW]
//   o_grant [NPORTS]      write may proceed
//   o_drop  [NPORTS]      write requested but lost arbitration
// -----------------------------------------------------------------------------
module mpram_wr_arbiter #(
  parameter int NPORTS = 4,
  parameter int AW     = 4
) (
  input  logic [NPORTS-1:0]    i_we,
  input  logic [NPORTS*AW-1:0] i_addr,
  output logic [NPORTS-1:0]    o_grant,
  output logic [NPORTS-1:0]    o_drop
);

  // Port p loses if any lower-index port requests the same address.
  always_comb begin
    o_grant = '0;
    for (int p = 0; p < NPORTS; p++) begin
      o_grant[p] = i_we[p];
      for (int q = 0; q < p; q++) begin
        if (i_we[q] && (i_addr[q*AW +: AW] == i_addr[p*AW +: AW])) begin
          o_grant[p] = 1'b0;
        end
      end
    end
  end

  assign o_drop = i_we & ~o_grant;

endmodule : mpram_wr_arbiter

// File: rtl/param_multiport_ram.sv
// -----------------------------------------------------------------------------
// param_multiport_ram
// N-port synchronous RAM. Every port reads and may write every cycle; there is
// no valid/ready handshake: each cycle's inputs are a complete request and the
// registered result appears on rdata/conflict after the next rising edge.
// Same-address write collisions are resolved lowest-port-wins, losers are
// flagged on conflict for one cycle. After reset a sweep clears every word
// before writes are accepted.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   we         [NPORTS]        per-port write enable
//   addr       [NPORTS*AW]     per-port address, port p at [p*AW +: AW]
//   wdata      [NPORTS*DW]     per-port write data, port p at [p*DW +: DW]
//   rdata      [NPORTS*DW]     registered read data
//   conflict   [NPORTS]        registered: port's write last cycle was dropped
//   init_busy  clear sweep in progress, writes ignored
//   dbg_state  current controller state (0 = INIT, 1 = RUN)
// -----------------------------------------------------------------------------
module param_multiport_ram
  import param_multiport_ram_pkg::*;
#(
  parameter int NPORTS   = MPRAM_DEF_NPORTS,
  parameter int DW       = MPRAM_DEF_DW,
  parameter int DEPTH    = MPRAM_DEF_DEPTH,
  parameter int AW       = mpram_clog2(DEPTH),
  parameter int RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [NPORTS*DW-1:0] rdata,
  output logic [NPORTS-1:0]    conflict,
  output logic                 init_busy,
  output logic                 dbg_state
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  mpram_state_t        r_state;
  logic [AW:0]         r_cnt;
  logic [DW-1:0]       r_mem [DEPTH];
  logic [NPORTS*DW-1:0] r_rdata;
  logic [NPORTS-1:0]   r_conflict;

  logic                w_run;
  logic [NPORTS-1:0]   w_we_run;
  logic [NPORTS-1:0]   w_grant;
  logic [NPORTS-1:0]   w_drop;
  logic [AW-1:0]       w_addr    [NPORTS];
  logic [DW-1:0]       w_wdata   [NPORTS];
  logic [DW-1:0]       w_rd_next [NPORTS];

  for (genvar gp = 0; gp < NPORTS; gp++) begin : g_unpack
    assign w_addr[gp]  = addr[gp*AW +: AW];
    assign w_wdata[gp] = wdata[gp*DW +: DW];
  end

  assign w_run = (r_state == ST_RUN);
  // Writes are masked during the sweep so they neither land nor raise conflict.
  assign w_we_run = we & {NPORTS{w_run}};

  mpram_wr_arbiter #(
    .NPORTS (NPORTS),
    .AW     (AW)
  ) u_arb (
    .i_we    (w_we_run),
    .i_addr  (addr),
    .o_grant (w_grant),
    .o_drop  (w_drop)
  );

  // Controller: INIT walks cnt over every word, then parks in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage. Not reset; the sweep provides the cleared contents. The rst_n
  // gate keeps edges seen while reset is held from clearing word 0 early.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      if (rst_n) begin
        r_mem[r_cnt[AW-1:0]] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_grant[p]) begin
          r_mem[w_addr[p]] <= w_wdata[p];
        end
      end
    end
  end

  // Read path with optional write-first bypass. Granted addresses are unique,
  // so at most one port can match any read address.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      w_rd_next[p] = r_mem[w_addr[p]];
      if (RDW_MODE == 1) begin
        for (int q = 0; q < NPORTS; q++) begin
          if (w_grant[q] && (w_addr[q] == w_addr[p])) begin
            w_rd_next[p] = w_wdata[q];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_conflict <= '0;
    end else if (r_state == ST_INIT) begin
      r_rdata    <= '0;
      r_conflict <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        r_rdata[p*DW +: DW] <= w_rd_next[p];
      end
      r_conflict <= w_drop;
    end
  end

  assign rdata     = r_rdata;
  assign conflict  = r_conflict;
  assign init_busy = (r_state == ST_INIT);
  assign dbg_state = r_state;

endmodule : param_multiport_ram

// File: tb/tb_param_multiport_ram.sv
// -----------------------------------------------------------------------------
// tb_param_multiport_ram
// Three instances: A (defaults, old-data read-during-write), B (defaults,
// write-first) driven by the same inputs, and C (2 ports, 16-bit, 64 words).
// Read cycles push the expected {conflict, rdata} onto a per-instance queue;
// monitors pop and compare on the falling edge after the active edge.
// -----------------------------------------------------------------------------
module tb_param_multiport_ram;

  logic        clk;
  logic        rst_n;
  logic        rst_n_c;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  conf_a, conf_b;
  logic        busy_a, busy_b;
  logic        dbg_a, dbg_b;

  logic [1:0]  we_c;
  logic [11:0] addr_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_c;
  logic [1:0]  conf_c;
  logic        busy_c;
  logic        dbg_c;

  logic [35:0] exp_a[$];
  logic [35:0] exp_b[$];
  logic [33:0] exp_c[$];
  logic        iss_ab, iss_c;
  logic        mon_ab, mon_c;

  int n_cmp;
  int n_bad;

  param_multiport_ram #(.RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .conflict(conf_a), .init_busy(busy_a), .dbg_state(dbg_a)
  );

  param_multiport_ram #(.RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .conflict(conf_b), .init_busy(busy_b), .dbg_state(dbg_b)
  );

  param_multiport_ram #(.NPORTS(2), .DW(16), .DEPTH(64)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
    .rdata(rdata_c), .conflict(conf_c), .init_busy(busy_c), .dbg_state(dbg_c)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    mon_ab <= iss_ab;
    mon_c  <= iss_c;
  end

  always @(negedge clk) begin
    logic [35:0] e36;
    logic [33:0] e34;
    if (mon_ab) begin
      if (exp_a.size() == 0) chk("a_queue_underflow", 1, 0);
      else begin
        e36 = exp_a.pop_front();
        chk("a_rdata", rdata_a, e36[31:0]);
        chk("a_conflict", conf_a, e36[35:32]);
      end
      if (exp_b.size() == 0) chk("b_queue_underflow", 1, 0);
      else begin
        e36 = exp_b.pop_front();
        chk("b_rdata", rdata_b, e36[31:0]);
        chk("b_conflict", conf_b, e36[35:32]);
      end
    end
    if (mon_c) begin
      if (exp_c.size() == 0) chk("c_queue_underflow", 1, 0);
      else begin
        e34 = exp_c.pop_front();
        chk("c_rdata", rdata_c, e34[31:0]);
        chk("c_conflict", conf_c, e34[33:32]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc_ab(input logic [3:0] w, input logic [15:0] a, input logic [31:0] d,
                        input logic c, input logic [35:0] ea, input logic [35:0] eb);
    we = w; addr = a; wdata = d; iss_ab = c;
    if (c) begin
      exp_a.push_back(ea);
      exp_b.push_back(eb);
    end
    @(posedge clk); #1;
    we = '0; iss_ab = 1'b0;
  endtask

  task automatic cyc_c(input logic [1:0] w, input logic [11:0] a, input logic [31:0] d,
                       input logic c, input logic [33:0] ec);
    we_c = w; addr_c = a; wdata_c = d; iss_c = c;
    if (c) exp_c.push_back(ec);
    @(posedge clk); #1;
    we_c = '0; iss_c = 1'b0;
  endtask

  // Counts edges while init_busy is high; called just after reset release.
  task automatic sweep_ab(input int expect_len);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk); n++; #1;
      if (!busy_a) break;
      chk("a_sweep_rdata_held", rdata_a, 0);
    end
    chk("a_sweep_len", n, expect_len);
    chk("b_busy_after_sweep", busy_b, 0);
    chk("a_state_run", dbg_a, 1);
  endtask

  task automatic sweep_c(input int expect_len);
    int n;
    n = 0;
    while (n < 300) begin
      @(posedge clk); n++; #1;
      if (!busy_c) break;
    end
    chk("c_sweep_len", n, expect_len);
    chk("c_state_run", dbg_c, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] vals  [4];
  logic [3:0] waddr [4];

  initial begin
    logic [15:0] a;
    logic [31:0] e;
    int idx;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; rst_n_c = 1'b0;
    we = '0; addr = '0; wdata = '0; iss_ab = 1'b0;
    we_c = '0; addr_c = '0; wdata_c = '0; iss_c = 1'b0;
    vals  = '{8'hAA, 8'h55, 8'h77, 8'h99};
    waddr = '{4'h3, 4'h7, 4'hA, 4'hF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_busy", busy_a, 1);
    chk("b_reset_busy", busy_b, 1);
    chk("a_reset_rdata", rdata_a, 0);
    chk("a_reset_conflict", conf_a, 0);
    chk("a_reset_state", dbg_a, 0);
    rst_n = 1'b1;
    sweep_ab(16);

    // Every word reads zero after the sweep
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) a[p*4 +: 4] = 4'(4*i + p);
      cyc_ab(4'b0000, a, 32'h0, 1'b1, 36'h0, 36'h0);
    end

    // Four ports write distinct addresses while reading them back
    cyc_ab(4'b1111, 16'hFA73, 32'h9977_55AA, 1'b1, {4'h0, 32'h0}, {4'h0, 32'h9977_55AA});
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        idx = (p + k) % 4;
        a[p*4 +: 4] = waddr[idx];
        e[p*8 +: 8] = vals[idx];
      end
      cyc_ab(4'b0000, a, 32'h0, 1'b1, {4'h0, e}, {4'h0, e});
    end

    // Two-way conflict at address 5: port 1 wins over port 3
    cyc_ab(4'b1010, 16'h5555, 32'h3300_1100, 1'b1, {4'b1000, 32'h0}, {4'b1000, 32'h1111_1111});
    cyc_ab(4'b0000, 16'h5555, 32'h0, 1'b1, {4'b0000, 32'h1111_1111}, {4'b0000, 32'h1111_1111});

    // Four-way conflict at address 9: port 0 wins
    cyc_ab(4'b1111, 16'h9999, 32'hE3E2_E1E0, 1'b1, {4'b1110, 32'h0}, {4'b1110, 32'hE0E0_E0E0});
    cyc_ab(4'b0000, 16'h9999, 32'h0, 1'b1, {4'b0000, 32'hE0E0_E0E0}, {4'b0000, 32'hE0E0_E0E0});

    // Read-during-write: location 2 holds 0x40, port 0 writes 0x41 there
    cyc_ab(4'b0001, 16'h0002, 32'h0000_0040, 1'b0, 36'h0, 36'h0);
    cyc_ab(4'b0001, 16'h7232, 32'h0000_0041, 1'b1, {4'h0, 32'h5540_AA40}, {4'h0, 32'h5541_AA41});
    cyc_ab(4'b0000, 16'h2222, 32'h0, 1'b1, {4'h0, 32'h4141_4141}, {4'h0, 32'h4141_4141});

    // Mid-operation reset with writes attempted during the sweep
    cyc_ab(4'b0001, 16'h0004, 32'h0000_00CC, 1'b0, 36'h0, 36'h0);
    cyc_ab(4'b0000, 16'h4444, 32'h0, 1'b1, {4'h0, 32'hCCCC_CCCC}, {4'h0, 32'hCCCC_CCCC});
    cyc_ab(4'b0000, 16'h0000, 32'h0, 1'b0, 36'h0, 36'h0);
    rst_n = 1'b0;
    #1;
    chk("a_midreset_rdata", rdata_a, 0);
    chk("a_midreset_conflict", conf_a, 0);
    chk("a_midreset_busy", busy_a, 1);
    chk("a_midreset_state", dbg_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    we = 4'b0001; addr = 16'h0004; wdata = 32'h0000_00DD;
    sweep_ab(16);
    we = '0;
    cyc_ab(4'b0000, 16'hFA34, 32'h0, 1'b1, 36'h0, 36'h0);
    cyc_ab(4'b0000, 16'h4444, 32'h0, 1'b1, 36'h0, 36'h0);
    cyc_ab(4'b0000, 16'h0000, 32'h0, 1'b0, 36'h0, 36'h0);

    // Parameter sweep instance: 2 ports, 16-bit, 64 words
    chk("c_reset_busy", busy_c, 1);
    chk("c_reset_rdata", rdata_c, 0);
    rst_n_c = 1'b1;
    sweep_c(64);
    cyc_c(2'b11, {6'd0, 6'd63}, 32'h1234_BEEF, 1'b1, {2'b00, 32'h0});
    cyc_c(2'b00, {6'd63, 6'd0}, 32'h0, 1'b1, {2'b00, 32'hBEEF_1234});
    cyc_c(2'b11, {6'd10, 6'd10}, 32'h0B0B_0A0A, 1'b1, {2'b10, 32'h0});
    cyc_c(2'b00, {6'd10, 6'd10}, 32'h0, 1'b1, {2'b00, 32'h0A0A_0A0A});

    // Drain
    repeat (2) @(posedge clk);
    #1;
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    chk("c_queue_drained", exp_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_param_multiport_ram
